// File: rtl/simulador_esteira.sv
// -----------------------------------------------------------------------------
// simulador_esteira
//
// Behavioural plant model of the wine-bottle conveyor. It takes the
// controllers' actuator commands (motor, fill valve, sealing actuator) and
// produces the station sensors and the bottle-full sensor. It stands in for the
// physical switches so the automation loop can run closed-loop. One bottle at a
// time travels from position 0 through the fill, quality-control and seal
// stations to the exit.
//
// Ports
//   clk                    system clock
//   reset                  asynchronous, active-low; clears all state
//   tick_en                one-cycle slow-rate enable; state advances only on it
//   motor                  conveyor motor on
//   valvula                fill valve open
//   atuador_vedacao        sealing actuator engaged
//   sensor_pos_enchimento  bottle at POS_ENCH
//   sensor_pos_cq          bottle at POS_CQ
//   sensor_pos_lacre       bottle at POS_LACRE
//   sensor_garrafa_cheia   fill level equals T_ENCH
//   garrafa_vedada         current bottle sealed
//   posicao[7:0]           current bottle position
//   garrafas_saida[7:0]    bottles that reached the exit (wraps 255 -> 0)
//   erro                   sticky plant fault (spill / overfill)
// -----------------------------------------------------------------------------
module simulador_esteira #(
  parameter int unsigned POS_ENCH  = 2,
  parameter int unsigned POS_CQ    = 6,
  parameter int unsigned POS_LACRE = 10,
  parameter int unsigned POS_FIM   = 14,
  parameter int unsigned PASSO     = 4,
  parameter int unsigned T_ENCH    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_en,
  input  logic       motor,
  input  logic       valvula,
  input  logic       atuador_vedacao,
  output logic       sensor_pos_enchimento,
  output logic       sensor_pos_cq,
  output logic       sensor_pos_lacre,
  output logic       sensor_garrafa_cheia,
  output logic       garrafa_vedada,
  output logic [7:0] posicao,
  output logic [7:0] garrafas_saida,
  output logic       erro
);

  localparam int unsigned PW = (PASSO > 1) ? $clog2(PASSO) : 1;

  localparam logic [7:0]    POS_ENCH_B  = 8'(POS_ENCH);
  localparam logic [7:0]    POS_CQ_B    = 8'(POS_CQ);
  localparam logic [7:0]    POS_LACRE_B = 8'(POS_LACRE);
  localparam logic [7:0]    POS_FIM_B   = 8'(POS_FIM);
  localparam logic [7:0]    T_ENCH_B    = 8'(T_ENCH);
  localparam logic [PW-1:0] PASSO_MAX   = PW'(PASSO - 1);

  typedef enum logic [1:0] {
    S_PARADA,
    S_MOVENDO,
    S_ENCHENDO,
    S_SAIDA
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [7:0]    pos_q, pos_d;
  logic [PW-1:0] passo_cnt_q, passo_cnt_d;
  logic [7:0]    nivel_q, nivel_d;
  logic          vedada_q, vedada_d;
  logic [7:0]    garrafas_q, garrafas_d;
  logic          erro_q, erro_d;
  logic          sens_ench_q, sens_ench_d;
  logic          sens_cq_q, sens_cq_d;
  logic          sens_lacre_q, sens_lacre_d;
  logic          cheia_q, cheia_d;
  logic          avanca;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch to hold it.
    estado_d    = estado_q;
    pos_d       = pos_q;
    passo_cnt_d = passo_cnt_q;
    nivel_d     = nivel_q;
    vedada_d    = vedada_q;
    garrafas_d  = garrafas_q;
    erro_d      = erro_q;
    avanca      = 1'b0;

    if (tick_en) begin
      // Valve open anywhere but the fill station, or while the belt runs,
      // pours wine onto the belt.
      if (valvula && (motor || (pos_q != POS_ENCH_B))) begin
        erro_d = 1'b1;
      end

      // Sealing only takes on a full, stationary bottle at the station.
      if (atuador_vedacao && !motor && (pos_q == POS_ENCH_B) &&
          (nivel_q == T_ENCH_B)) begin
        vedada_d = 1'b1;
      end

      unique case (estado_q)
        S_PARADA: begin
          // The belt starts moving on the same tick the motor comes on, so
          // this tick already counts towards the first step.
          if (motor) begin
            estado_d = S_MOVENDO;
            avanca   = 1'b1;
          end else if (valvula && (pos_q == POS_ENCH_B)) begin
            estado_d = S_ENCHENDO;
          end
        end
        S_MOVENDO: begin
          if (motor) begin
            avanca = 1'b1;
          end else begin
            passo_cnt_d = '0;  // partial step is lost
            estado_d    = S_PARADA;
          end
        end
        S_ENCHENDO: begin
          if (motor) begin
            erro_d   = 1'b1;   // belt pulled away mid-fill
            estado_d = S_MOVENDO;
            avanca   = 1'b1;
          end else if (!valvula) begin
            estado_d = S_PARADA;
          end else if (nivel_q == T_ENCH_B) begin
            erro_d = 1'b1;     // overfill; level saturates
          end else begin
            nivel_d = nivel_q + 8'd1;
          end
        end
        S_SAIDA: begin
          // Bottle leaves; a fresh empty bottle appears at position 0.
          garrafas_d  = garrafas_q + 8'd1;
          pos_d       = '0;
          nivel_d     = '0;
          vedada_d    = 1'b0;
          passo_cnt_d = '0;
          estado_d    = motor ? S_MOVENDO : S_PARADA;
        end
        default: estado_d = S_PARADA;
      endcase

      if (avanca) begin
        if (passo_cnt_q == PASSO_MAX) begin
          passo_cnt_d = '0;
          pos_d       = pos_q + 8'd1;
          if ((pos_q + 8'd1) == POS_FIM_B) begin
            estado_d = S_SAIDA;
          end
        end else begin
          passo_cnt_d = passo_cnt_q + PW'(1);
        end
      end
    end

    // Sensors are registered alongside the state they decode.
    sens_ench_d  = (pos_d == POS_ENCH_B);
    sens_cq_d    = (pos_d == POS_CQ_B);
    sens_lacre_d = (pos_d == POS_LACRE_B);
    cheia_d      = (nivel_d == T_ENCH_B);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q     <= S_PARADA;
      pos_q        <= '0;
      passo_cnt_q  <= '0;
      nivel_q      <= '0;
      vedada_q     <= 1'b0;
      garrafas_q   <= '0;
      erro_q       <= 1'b0;
      sens_ench_q  <= 1'b0;
      sens_cq_q    <= 1'b0;
      sens_lacre_q <= 1'b0;
      cheia_q      <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      pos_q        <= pos_d;
      passo_cnt_q  <= passo_cnt_d;
      nivel_q      <= nivel_d;
      vedada_q     <= vedada_d;
      garrafas_q   <= garrafas_d;
      erro_q       <= erro_d;
      sens_ench_q  <= sens_ench_d;
      sens_cq_q    <= sens_cq_d;
      sens_lacre_q <= sens_lacre_d;
      cheia_q      <= cheia_d;
    end
  end

  assign sensor_pos_enchimento = sens_ench_q;
  assign sensor_pos_cq         = sens_cq_q;
  assign sensor_pos_lacre      = sens_lacre_q;
  assign sensor_garrafa_cheia  = cheia_q;
  assign garrafa_vedada        = vedada_q;
  assign posicao               = pos_q;
  assign garrafas_saida        = garrafas_q;
  assign erro                  = erro_q;

endmodule

// File: tb/tb_simulador_esteira.sv
// -----------------------------------------------------------------------------
// tb_simulador_esteira
//
// Directed bench for simulador_esteira with default parameters
// (POS_ENCH=2, POS_CQ=6, POS_LACRE=10, POS_FIM=14, PASSO=4, T_ENCH=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after each tick_en pulse.
// -----------------------------------------------------------------------------
module tb_simulador_esteira;

  logic       clk;
  logic       reset;
  logic       tick_en;
  logic       motor;
  logic       valvula;
  logic       atuador_vedacao;
  logic       sensor_pos_enchimento;
  logic       sensor_pos_cq;
  logic       sensor_pos_lacre;
  logic       sensor_garrafa_cheia;
  logic       garrafa_vedada;
  logic [7:0] posicao;
  logic [7:0] garrafas_saida;
  logic       erro;

  int checks = 0;
  int errors = 0;

  simulador_esteira dut (
    .clk                   (clk),
    .reset                 (reset),
    .tick_en               (tick_en),
    .motor                 (motor),
    .valvula               (valvula),
    .atuador_vedacao       (atuador_vedacao),
    .sensor_pos_enchimento (sensor_pos_enchimento),
    .sensor_pos_cq         (sensor_pos_cq),
    .sensor_pos_lacre      (sensor_pos_lacre),
    .sensor_garrafa_cheia  (sensor_garrafa_cheia),
    .garrafa_vedada        (garrafa_vedada),
    .posicao               (posicao),
    .garrafas_saida        (garrafas_saida),
    .erro                  (erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One tick_en pulse, one clock wide, followed by one idle cycle.
  task automatic tick();
    @(negedge clk);
    tick_en = 1'b1;
    @(negedge clk);
    tick_en = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    motor           = 1'b0;
    valvula         = 1'b0;
    atuador_vedacao = 1'b0;
    tick_en         = 1'b0;
    reset           = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset           = 1'b1;
    tick_en         = 1'b0;
    motor           = 1'b0;
    valvula         = 1'b0;
    atuador_vedacao = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ench",     sensor_pos_enchimento, 8'd0);
    check("rst_cq",       sensor_pos_cq,         8'd0);
    check("rst_lacre",    sensor_pos_lacre,      8'd0);
    check("rst_cheia",    sensor_garrafa_cheia,  8'd0);
    check("rst_vedada",   garrafa_vedada,        8'd0);
    check("rst_posicao",  posicao,               8'd0);
    check("rst_garrafas", garrafas_saida,        8'd0);
    check("rst_erro",     erro,                  8'd0);
    reset = 1'b1;
    @(negedge clk);

    // Full trip with motor held on: one step every 4 ticks, exit at tick 57.
    motor = 1'b1;
    for (int t = 1; t <= 57; t++) begin
      tick();
      case (t)
        3:  check("trip_pos_t3", posicao, 8'd0);
        4: begin
          check("trip_pos_t4", posicao, 8'd1);
          // Clocks without tick_en change nothing.
          repeat (8) @(negedge clk);
          check("hold_no_tick", posicao, 8'd1);
        end
        7:  check("trip_ench_t7", sensor_pos_enchimento, 8'd0);
        8: begin
          check("trip_ench_t8", sensor_pos_enchimento, 8'd1);
          check("trip_pos_t8",  posicao,               8'd2);
        end
        11: check("trip_ench_t11", sensor_pos_enchimento, 8'd1);
        12: begin
          check("trip_ench_t12", sensor_pos_enchimento, 8'd0);
          check("trip_pos_t12",  posicao,               8'd3);
        end
        23: check("trip_cq_t23",    sensor_pos_cq,    8'd0);
        24: check("trip_cq_t24",    sensor_pos_cq,    8'd1);
        27: check("trip_cq_t27",    sensor_pos_cq,    8'd1);
        28: check("trip_cq_t28",    sensor_pos_cq,    8'd0);
        39: check("trip_lacre_t39", sensor_pos_lacre, 8'd0);
        40: check("trip_lacre_t40", sensor_pos_lacre, 8'd1);
        43: check("trip_lacre_t43", sensor_pos_lacre, 8'd1);
        44: check("trip_lacre_t44", sensor_pos_lacre, 8'd0);
        56: begin
          check("trip_pos_t56",      posicao,        8'd14);
          check("trip_garrafas_t56", garrafas_saida, 8'd0);
        end
        57: begin
          check("trip_pos_t57",      posicao,        8'd0);
          check("trip_garrafas_t57", garrafas_saida, 8'd1);
        end
        default: ;
      endcase
    end

    // Fill at the station: cheia after 9 valve ticks, overfill on the 10th.
    do_reset();
    motor = 1'b1;
    ticks(8);
    check("fill_pos_station", posicao,               8'd2);
    check("fill_ench_sensor", sensor_pos_enchimento, 8'd1);
    motor = 1'b0;
    tick();
    check("fill_pos_stopped", posicao, 8'd2);
    valvula = 1'b1;
    ticks(8);
    check("fill_cheia_8", sensor_garrafa_cheia, 8'd0);
    tick();
    check("fill_cheia_9", sensor_garrafa_cheia, 8'd1);
    check("fill_erro_9",  erro,                 8'd0);
    tick();
    check("overfill_erro",  erro,                 8'd1);
    check("overfill_cheia", sensor_garrafa_cheia, 8'd1);

    // Asynchronous reset mid-cycle, no clock edge in between.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_erro",  erro,                  8'd0);
    check("async_rst_cheia", sensor_garrafa_cheia,  8'd0);
    check("async_rst_ench",  sensor_pos_enchimento, 8'd0);
    check("async_rst_pos",   posicao,               8'd0);
    valvula = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Sealing a full bottle at the fill station.
    motor = 1'b1;
    ticks(8);
    motor = 1'b0;
    tick();
    valvula = 1'b1;
    ticks(9);
    valvula = 1'b0;
    tick();
    check("seal_before", garrafa_vedada, 8'd0);
    atuador_vedacao = 1'b1;
    tick();
    atuador_vedacao = 1'b0;
    check("seal_after",      garrafa_vedada, 8'd1);
    check("seal_after_erro", erro,           8'd0);
    motor = 1'b1;
    ticks(48);
    check("seal_pos_fim",    posicao,        8'd14);
    check("seal_kept_fim",   garrafa_vedada, 8'd1);
    tick();
    check("exit_pos",        posicao,              8'd0);
    check("exit_vedada_clr", garrafa_vedada,       8'd0);
    check("exit_cheia_clr",  sensor_garrafa_cheia, 8'd0);
    check("exit_garrafas",   garrafas_saida,       8'd1);
    ticks(24);
    check("new_pos_cq",    posicao,       8'd6);
    check("new_sensor_cq", sensor_pos_cq, 8'd1);
    motor = 1'b0;
    tick();
    atuador_vedacao = 1'b1;
    tick();
    atuador_vedacao = 1'b0;
    check("seal_cq_none",      garrafa_vedada, 8'd0);
    check("seal_cq_none_erro", erro,           8'd0);

    // Spill: valve opened while the belt runs.
    do_reset();
    motor = 1'b1;
    ticks(12);
    check("spill_pos",         posicao, 8'd3);
    check("spill_erro_before", erro,    8'd0);
    valvula = 1'b1;
    tick();
    valvula = 1'b0;
    check("spill_erro", erro, 8'd1);
    ticks(5);
    check("spill_erro_sticky", erro, 8'd1);
    do_reset();
    check("spill_erro_reset", erro, 8'd0);

    // Partial step lost when the motor drops at passo_cnt=2.
    motor = 1'b1;
    ticks(2);
    motor = 1'b0;
    tick();
    check("partial_pos_stop", posicao, 8'd0);
    motor = 1'b1;
    ticks(3);
    check("partial_pos_3", posicao, 8'd0);
    tick();
    check("partial_pos_4", posicao, 8'd1);
    ticks(2);
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("midstep_rst_pos", posicao, 8'd0);
    motor = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Exit counter wraps after 256 bottles (57 ticks per bottle).
    do_reset();
    motor = 1'b1;
    ticks(255 * 57);
    check("wrap_255_count", garrafas_saida, 8'd255);
    check("wrap_255_pos",   posicao,        8'd0);
    ticks(57);
    check("wrap_256_count", garrafas_saida, 8'd0);
    check("wrap_256_pos",   posicao,        8'd0);
    motor = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simulador_esteira.md
# simulador_esteira

Behavioural plant model of the wine-bottle conveyor: it answers the process and motor controllers' commands (motor, fill valve, sealing actuator) with the station sensors and bottle-full sensor they consume. It sits on the plant side of the controller's sensor interface, in place of the physical switches, so the complete automation loop runs closed-loop on the board and in simulation. The model tracks one bottle at a time through fill, quality-control and seal stations to the exit.

## Interface
- POS_ENCH, default 2: belt position of the fill/seal station.
- POS_CQ, default 6: position of the quality-control station.
- POS_LACRE, default 10: position of the seal/count station.
- POS_FIM, default 14: exit position; must satisfy 0 < POS_ENCH < POS_CQ < POS_LACRE < POS_FIM ≤ 255.
- PASSO, default 4: tick_en pulses per one-position belt step (≥1).
- T_ENCH, default 8: tick_en pulses of open valve to fill a bottle (1..255).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; clears all state.
- tick_en  in  1  one-cycle slow-rate enable (same pulse as the controllers' slow clock enable); all state advances only on it.
- motor  in  1  conveyor motor on.
- valvula  in  1  fill valve open.
- atuador_vedacao  in  1  sealing actuator engaged.
- sensor_pos_enchimento  out  1  bottle at POS_ENCH.
- sensor_pos_cq  out  1  bottle at POS_CQ.
- sensor_pos_lacre  out  1  bottle at POS_LACRE.
- sensor_garrafa_cheia  out  1  fill level = T_ENCH.
- garrafa_vedada  out  1  current bottle sealed.
- posicao  out  8  current bottle position.
- garrafas_saida  out  8  bottles that reached exit, wraps 255→0.
- erro  out  1  sticky plant fault (spill/overfill).

## Operation
- State: pos (8 b), passo_cnt, nivel (8 b), vedada, garrafas_saida, erro; FSM S_PARADA, S_MOVENDO, S_ENCHENDO, S_SAIDA.
- Reset: pos=0, passo_cnt=0, nivel=0, vedada=0, garrafas_saida=0, erro=0, FSM=S_PARADA; all outputs 0.
- Nothing changes on cycles without tick_en.
- S_PARADA: motor=1 → S_MOVENDO; else valvula=1 and pos=POS_ENCH → S_ENCHENDO.
- S_MOVENDO: each tick_en passo_cnt++; at PASSO-1, passo_cnt=0, pos++. motor=0 → passo_cnt=0, S_PARADA (partial step lost). pos reaching POS_FIM → S_SAIDA.
- S_ENCHENDO: each tick_en with valvula=1, nivel++ saturating at T_ENCH; valvula=0 → S_PARADA; valvula=1 with nivel already T_ENCH → erro=1 (overfill), level held; motor=1 → erro=1, S_MOVENDO.
- S_SAIDA: one tick_en: garrafas_saida++, pos=0, nivel=0, vedada=0, passo_cnt=0, next state S_MOVENDO if motor=1 else S_PARADA.
- Sealing: on any tick_en with atuador_vedacao=1, pos=POS_ENCH, nivel=T_ENCH, motor=0 → vedada=1. Actuator elsewhere or on unfull bottle: no effect, no error.
- Spill: valvula=1 on tick_en with pos≠POS_ENCH or motor=1 → erro=1.
- erro clears only on reset.
- Sensors: sensor_pos_x = (pos == POS_x); sensor_garrafa_cheia = (nivel == T_ENCH). Sensors stay high while the bottle rests at a station.

## Timing
- All outputs registered; update in the cycle after the tick_en edge that changes state.
- Motor on at POS_ENCH-1 with passo_cnt=0: sensor_pos_enchimento rises after exactly PASSO tick_en pulses, falls PASSO pulses later if motor stays on.
- Fill from empty with valve held open at station: sensor_garrafa_cheia rises after T_ENCH tick_en pulses in S_ENCHENDO (first pulse only moves S_PARADA→S_ENCHENDO).
- Exit: pos=POS_FIM holds for exactly one tick_en, then pos=0, counter +1.
- Reset mid-operation: all outputs 0 asynchronously, regardless of tick_en.

## Test plan
- Reset, motor=1 continuous, PASSO=4: posicao steps every 4 tick_en; sensor_pos_enchimento high for tick_en 8..11, sensor_pos_cq at 24..27, sensor_pos_lacre at 40..43; garrafas_saida=1 after tick 57, posicao=0.
- Stop at POS_ENCH, valvula=1 for 9 ticks, T_ENCH=8: sensor_garrafa_cheia=1 after 9th tick, erro=0; 10th valve tick → erro=1.
- Full bottle at POS_ENCH, atuador_vedacao=1 one tick → garrafa_vedada=1; same pulse at POS_CQ on new bottle → stays 0.
- valvula=1 while motor=1 at pos 3 → erro=1 next tick, persists until reset.
- motor dropped at passo_cnt=2, re-raised: next step needs full PASSO=4 ticks; reset asserted mid-step → all outputs 0 immediately; 256 bottle exits → garrafas_saida wraps to 0.
